note_chart_sequencer: RTL and testbench

//   Plays a note chart by stepping through a chart ROM and issuing do/ka spawn requests on frame ticks.

---
 rtl/note_chart_sequencer.sv | 132 +++++++++++++
 tb/tb_note_chart_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_chart_sequencer.sv
// Chart player: walks a registered-address chart ROM and pulses do/ka spawn requests on frame ticks.
// request is combinational in the firing vsync cycle; all other outputs are registered, and pause freezes counting.
module note_chart_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DELTA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               start,
  input  logic               pause,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DELTA_W+1:0] rom_data,
  output logic [1:0]         request,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  note_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]  note_cnt_q, note_cnt_d;
  logic [DELTA_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]         type_q, type_d;
  logic [DELTA_W-1:0] delta_q, delta_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tick_ok;
  logic [DELTA_W-1:0] delta_eff;
  logic [DELTA_W:0]   frame_inc;
  logic               fire_ok;
  logic               fire;
  logic [DELTA_W-1:0] frame_sat_inc;
  logic [ADDR_W-1:0]  note_sat_inc;

  assign tick_ok   = vsync & ~pause;
  assign delta_eff = (delta_q == '0) ? DELTA_W'(1) : delta_q;
  // One bit wider so a saturated frame count still compares as "reached".
  assign frame_inc = {1'b0, frame_cnt_q} + (DELTA_W+1)'(1);
  assign fire_ok   = (frame_inc >= {1'b0, delta_eff});
  assign fire      = (state_q == S_COUNT) && tick_ok && fire_ok;

  assign frame_sat_inc = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + DELTA_W'(1);
  assign note_sat_inc  = (&note_cnt_q) ? note_cnt_q : note_cnt_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    note_cnt_d  = note_cnt_q;
    frame_cnt_d = frame_cnt_q;
    type_d      = type_q;
    delta_d     = delta_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rom_addr_d  = '0;
          note_cnt_d  = '0;
          frame_cnt_d = '0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (tick_ok) frame_cnt_d = frame_sat_inc;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick_ok) frame_cnt_d = frame_sat_inc;
        type_d  = rom_data[DELTA_W+1:DELTA_W];
        delta_d = rom_data[DELTA_W-1:0];
        state_d = (rom_data[DELTA_W+1:DELTA_W] == 2'b00) ? S_DONE : S_COUNT;
      end
      S_COUNT: begin
        if (tick_ok) begin
          if (fire_ok) begin
            frame_cnt_d = '0;
            note_cnt_d  = note_sat_inc;
            // The last ROM slot ends the chart even without an explicit end entry.
            if (&rom_addr_q) begin
              state_d = S_DONE;
            end else begin
              rom_addr_d = rom_addr_q + ADDR_W'(1);
              state_d    = S_FETCH;
            end
          end else begin
            frame_cnt_d = frame_sat_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_COUNT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      note_cnt_q  <= '0;
      frame_cnt_q <= '0;
      type_q      <= 2'b00;
      delta_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      note_cnt_q  <= note_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      type_q      <= type_d;
      delta_q     <= delta_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign request  = fire ? type_q : 2'b00;
  assign rom_addr = rom_addr_q;
  assign note_cnt = note_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_note_chart_sequencer.sv
// Scoreboard bench: expected spawn pulses (type, vsync index) are queued per test and popped by monitors.
module tb_note_chart_sequencer;

  logic       clk;
  logic       rst;
  logic       vsync;
  logic       pause;
  logic       start_a;
  logic       start_b;
  logic [7:0] rom_addr_a;
  logic [9:0] rom_data_a;
  logic [1:0] request_a;
  logic       busy_a;
  logic       done_a;
  logic [7:0] note_cnt_a;
  logic [1:0] rom_addr_b;
  logic [9:0] rom_data_b;
  logic [1:0] request_b;
  logic       busy_b;
  logic       done_b;
  logic [1:0] note_cnt_b;

  logic [9:0] rom_a [0:255];
  logic [9:0] rom_b [0:3];

  typedef struct {
    logic [1:0] typ;
    int         frame;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   vidx;
  int   n_checks;
  int   n_pass;

  note_chart_sequencer #(.ADDR_W(8), .DELTA_W(8)) dut_a (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start_a), .pause(pause),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .request(request_a),
    .busy(busy_a), .done(done_a), .note_cnt(note_cnt_a)
  );

  note_chart_sequencer #(.ADDR_W(2), .DELTA_W(8)) dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .start(start_b), .pause(pause),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .request(request_b),
    .busy(busy_b), .done(done_b), .note_cnt(note_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_b[rom_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (request_a != 2'b00) begin
      if (qa.size() == 0) begin
        check("req_a_unexpected", {30'd0, request_a}, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("req_a_type", {30'd0, request_a}, {30'd0, e.typ});
        check("req_a_frame", vidx, e.frame);
      end
    end
  end

  always @(negedge clk) begin
    if (request_b != 2'b00) begin
      if (qb.size() == 0) begin
        check("req_b_unexpected", {30'd0, request_b}, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("req_b_type", {30'd0, request_b}, {30'd0, e.typ});
        check("req_b_frame", vidx, e.frame);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int gap);
    repeat (gap - 1) tick();
    vsync = 1'b1;
    vidx++;
    tick();
    vsync = 1'b0;
  endtask

  task automatic push_a(input logic [1:0] t, input int f);
    exp_t e;
    e.typ = t;
    e.frame = f;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] t, input int f);
    exp_t e;
    e.typ = t;
    e.frame = f;
    qb.push_back(e);
  endtask

  task automatic go_a();
    vidx = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    vidx     = 0;
    rst      = 1'b1;
    vsync    = 1'b0;
    pause    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    for (int i = 0; i < 256; i++) rom_a[i] = 10'd0;
    for (int i = 0; i < 4; i++) rom_b[i] = 10'd0;
    repeat (3) tick();
    check("rst_addr", {24'd0, rom_addr_a}, 32'd0);
    check("rst_note", {24'd0, note_cnt_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_req", {30'd0, request_a}, 32'd0);
    rst = 1'b0;
    tick();

    // do after 3 frames, ka one frame later, then end marker
    rom_a[0] = {2'b01, 8'd3};
    rom_a[1] = {2'b10, 8'd1};
    rom_a[2] = {2'b00, 8'd0};
    push_a(2'b01, 3);
    push_a(2'b10, 4);
    go_a();
    repeat (4) frame(20);
    repeat (4) tick();
    check("t1_done", {31'd0, done_a}, 32'd1);
    check("t1_busy", {31'd0, busy_a}, 32'd0);
    check("t1_note", {24'd0, note_cnt_a}, 32'd2);
    frame(20);
    check("t1_queue", qa.size(), 32'd0);

    // zero delta behaves as one
    rom_a[0] = {2'b11, 8'd0};
    rom_a[1] = {2'b00, 8'd0};
    push_a(2'b11, 1);
    go_a();
    check("t2_note_clr", {24'd0, note_cnt_a}, 32'd0);
    frame(20);
    repeat (4) tick();
    check("t2_done", {31'd0, done_a}, 32'd1);
    check("t2_queue", qa.size(), 32'd0);

    // paused vsyncs 2 and 3 are not counted
    rom_a[0] = {2'b01, 8'd4};
    push_a(2'b01, 6);
    go_a();
    frame(20);
    pause = 1'b1;
    frame(20);
    frame(20);
    pause = 1'b0;
    frame(20);
    frame(20);
    check("t3_early", qa.size(), 32'd1);
    frame(20);
    repeat (4) tick();
    check("t3_queue", qa.size(), 32'd0);
    check("t3_note", {24'd0, note_cnt_a}, 32'd1);

    // async reset mid-chart, then replay
    rom_a[0] = {2'b01, 8'd1};
    rom_a[1] = {2'b10, 8'd8};
    rom_a[2] = {2'b00, 8'd0};
    push_a(2'b01, 1);
    go_a();
    frame(20);
    repeat (4) tick();
    check("t4_pre_note", {24'd0, note_cnt_a}, 32'd1);
    check("t4_pre_busy", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    #1;
    check("t4_addr", {24'd0, rom_addr_a}, 32'd0);
    check("t4_note", {24'd0, note_cnt_a}, 32'd0);
    check("t4_busy", {31'd0, busy_a}, 32'd0);
    check("t4_req", {30'd0, request_a}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rom_a[1] = {2'b00, 8'd0};
    push_a(2'b01, 1);
    go_a();
    check("t4_replay_addr", {24'd0, rom_addr_a}, 32'd0);
    frame(20);
    repeat (4) tick();
    check("t4_replay_done", {31'd0, done_a}, 32'd1);
    check("t4_queue", qa.size(), 32'd0);

    // start held while busy is ignored
    rom_a[0] = {2'b01, 8'd2};
    rom_a[1] = {2'b10, 8'd2};
    rom_a[2] = {2'b00, 8'd0};
    push_a(2'b01, 2);
    push_a(2'b10, 4);
    go_a();
    frame(20);
    frame(20);
    start_a = 1'b1;
    repeat (10) tick();
    start_a = 1'b0;
    check("t6_addr", {24'd0, rom_addr_a}, 32'd1);
    check("t6_note", {24'd0, note_cnt_a}, 32'd1);
    check("t6_busy", {31'd0, busy_a}, 32'd1);
    frame(20);
    frame(20);
    repeat (4) tick();
    check("t6_note_end", {24'd0, note_cnt_a}, 32'd2);
    check("t6_queue", qa.size(), 32'd0);

    // small ROM with no end marker: implicit end and saturated count
    rom_b[0] = {2'b01, 8'd1};
    rom_b[1] = {2'b10, 8'd2};
    rom_b[2] = {2'b11, 8'd1};
    rom_b[3] = {2'b01, 8'd1};
    push_b(2'b01, 1);
    push_b(2'b10, 3);
    push_b(2'b11, 4);
    push_b(2'b01, 5);
    vidx = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (5) frame(20);
    repeat (2) tick();
    check("t5_done", {31'd0, done_b}, 32'd1);
    check("t5_note", {30'd0, note_cnt_b}, 32'd3);
    check("t5_queue", qb.size(), 32'd0);
    push_b(2'b01, 1);
    vidx = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("t5_restart_addr", {30'd0, rom_addr_b}, 32'd0);
    check("t5_restart_note", {30'd0, note_cnt_b}, 32'd0);
    check("t5_restart_busy", {31'd0, busy_b}, 32'd1);
    frame(20);
    repeat (4) tick();
    check("t5_restart_queue", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
